// File: rtl/coef_seq_ctrl_pkg.sv
// Shared definitions for the coefficient sequencer: FSM state encoding and
// default geometry of the coefficient ROM walk.
package coef_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int NUM_TAPS_DEF   = 4;
  localparam int ADDR_WIDTH_DEF = 2;

endpackage

// File: rtl/coef_seq_ctrl.sv
// Coefficient sequencer: takes one sample per handshake, walks the external
// coefficient ROM and drives registered MAC strobes, then holds result-valid.
module coef_seq_ctrl
  import coef_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_TAPS   = NUM_TAPS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_soft_clr,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic [ADDR_WIDTH-1:0] o_rom_r_address,
  input  logic [DATA_WIDTH-1:0] i_rom_r_data,
  output logic                  o_mac_clr,
  output logic                  o_mac_en,
  output logic [DATA_WIDTH-1:0] o_mac_coef,
  output logic [DATA_WIDTH-1:0] o_mac_sample,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_tap_cnt;
  logic [CNT_W-1:0]      w_tap_nxt;
  logic                  w_mac_en_nxt;
  logic                  w_mac_clr_nxt;
  logic                  w_coef_load;
  logic                  w_sample_load;
  logic                  w_out_valid_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_mac_en;
  logic                  r_mac_clr;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_mac_coef;
  logic [DATA_WIDTH-1:0] r_mac_sample;

  // Next-state and next-output decode; soft clear overrides every state.
  always_comb begin
    w_state_nxt     = r_state;
    w_tap_nxt       = r_tap_cnt;
    w_mac_en_nxt    = 1'b0;
    w_mac_clr_nxt   = 1'b0;
    w_coef_load     = 1'b0;
    w_sample_load   = 1'b0;
    w_out_valid_nxt = r_out_valid;
    if (i_soft_clr) begin
      w_state_nxt     = ST_IDLE;
      w_tap_nxt       = {CNT_W{1'b0}};
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_tap_nxt       = {CNT_W{1'b0}};
          w_out_valid_nxt = 1'b0;
          if (i_in_valid) begin
            w_sample_load = 1'b1;
            w_state_nxt   = ST_RUN;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end
        ST_RUN: begin
          w_coef_load   = 1'b1;
          w_mac_en_nxt  = 1'b1;
          w_mac_clr_nxt = (r_tap_cnt == {CNT_W{1'b0}});
          w_tap_nxt     = r_tap_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_tap_cnt == LAST_TAP) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          w_state_nxt     = ST_DONE;
          w_out_valid_nxt = 1'b1;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
          end else begin
            w_state_nxt     = ST_DONE;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_tap_nxt       = {CNT_W{1'b0}};
          w_out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // The ROM address register tracks the tap about to be read, so it equals tap_cnt while in RUN.
  always_comb begin
    if (w_state_nxt == ST_RUN) begin
      w_addr_nxt = w_tap_nxt[ADDR_WIDTH-1:0];
    end else begin
      w_addr_nxt = {ADDR_WIDTH{1'b0}};
    end
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tap_cnt    <= {CNT_W{1'b0}};
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_mac_en     <= 1'b0;
      r_mac_clr    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_rom_addr   <= {ADDR_WIDTH{1'b0}};
      r_mac_coef   <= {DATA_WIDTH{1'b0}};
      r_mac_sample <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_tap_cnt   <= w_tap_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_mac_en    <= w_mac_en_nxt;
      r_mac_clr   <= w_mac_clr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_rom_addr  <= w_addr_nxt;
      if (w_coef_load) begin
        r_mac_coef <= i_rom_r_data;
      end else begin
        r_mac_coef <= r_mac_coef;
      end
      if (w_sample_load) begin
        r_mac_sample <= i_in_data;
      end else begin
        r_mac_sample <= r_mac_sample;
      end
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_busy          = r_busy;
  assign o_mac_en        = r_mac_en;
  assign o_mac_clr       = r_mac_clr;
  assign o_out_valid     = r_out_valid;
  assign o_rom_r_address = r_rom_addr;
  assign o_mac_coef      = r_mac_coef;
  assign o_mac_sample    = r_mac_sample;

endmodule

// File: tb/tb_coef_seq_ctrl.sv
// Bench for coef_seq_ctrl: ROM, reference MAC, timeline model of a sample's
// life, directed scenarios and a randomized soak.
module tb_coef_seq_ctrl;

  localparam int DW = 12;
  localparam int NT = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          soft_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          mac_clr;
  logic          mac_en;
  logic [DW-1:0] mac_coef;
  logic [DW-1:0] mac_sample;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  logic [DW-1:0] rom [NT] = '{12'h400, 12'hE00, 12'h140, 12'hF80};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  coef_seq_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_soft_clr      (soft_clr),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_data       (in_data),
    .o_rom_r_address (rom_addr),
    .i_rom_r_data    (rom_data),
    .o_mac_clr       (mac_clr),
    .o_mac_en        (mac_en),
    .o_mac_coef      (mac_coef),
    .o_mac_sample    (mac_sample),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  // Expected final accumulator for a sample: signed dot product with all ROM words.
  function automatic int dot(input logic [DW-1:0] s);
    int sum = 0;
    for (int i = 0; i < NT; i++) begin
      sum += int'($signed(rom[i])) * int'($signed(s));
    end
    return sum;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference MAC fed from the DUT strobes.
  int acc = 0;
  always @(posedge clk) begin
    if (mac_en) begin
      acc <= (mac_clr ? 0 : acc) + int'($signed(mac_coef)) * int'($signed(mac_sample));
    end
  end

  // Timeline model: m_k counts edges since the accept edge of the live sample.
  bit          m_active = 1'b0;
  int          m_k      = 0;
  logic [DW-1:0] m_sample = '0;
  logic [DW-1:0] m_coef   = '0;
  int          m_res    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_sample <= '0;
      m_coef   <= '0;
    end else if (soft_clr) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_sample <= in_data;
        m_res    <= dot(in_data);
      end
    end else if (m_k < NT) begin
      m_coef <= rom[m_k];
      m_k    <= m_k + 1;
    end else if (m_k == NT) begin
      m_k <= NT + 1;
    end else if (out_ready) begin
      m_active <= 1'b0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(in_ready),  int'(!m_active));
      check("busy",      int'(busy),      int'(m_active));
      check("mac_en",    int'(mac_en),    int'(m_active && m_k >= 1 && m_k <= NT));
      check("mac_clr",   int'(mac_clr),   int'(m_active && m_k == 1));
      check("out_valid", int'(out_valid), int'(m_active && m_k == NT + 1));
      check("rom_addr",  int'(rom_addr),  (m_active && m_k < NT) ? m_k : 0);
      check("mac_coef",  int'(mac_coef),  int'(m_coef));
      check("mac_sample", int'(mac_sample), int'(m_sample));
      if (m_active && m_k == NT + 1) begin
        check("result", acc, m_res);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!in_ready && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", int'(in_ready), 1);
  endtask

  logic [DW-1:0] exp_coef [NT] = '{12'h400, 12'hE00, 12'h140, 12'hF80};
  int n_acc;

  initial begin
    // Reset state, applied asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_mac_en",   int'(mac_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",     int'(busy), 0);
    check("dot_pin_pos",  dot(12'h100), 180224);
    check("dot_pin_neg",  dot(12'hFFF), -704);
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Async reset in the middle of the tap walk.
    out_ready = 1'b1;
    send(12'h07F);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t1_mac_en",    int'(mac_en), 0);
    check("t1_mac_clr",   int'(mac_clr), 0);
    check("t1_out_valid", int'(out_valid), 0);
    check("t1_in_ready",  int'(in_ready), 1);
    check("t1_addr",      int'(rom_addr), 0);
    check("t1_coef",      int'(mac_coef), 0);
    check("t1_sample",    int'(mac_sample), 0);
    step();
    rst_n = 1'b1;
    step();

    // Single sample, literal per-tap expectations.
    send(12'h100);
    for (int i = 0; i < NT; i++) begin
      step();
      check("t2_coef", int'(mac_coef), int'(exp_coef[i]));
      check("t2_en",   int'(mac_en), 1);
      check("t2_clr",  int'(mac_clr), (i == 0) ? 1 : 0);
    end
    step();
    check("t2_en_drop", int'(mac_en), 0);
    check("t2_ov",      int'(out_valid), 1);
    check("t2_result",  acc, 180224);
    step();
    check("t2_ov_drop", int'(out_valid), 0);
    check("t2_ready",   int'(in_ready), 1);

    // Consumer stalls in DONE while new samples are offered.
    out_ready = 1'b0;
    send(12'h3A5);
    in_valid = 1'b1;
    in_data  = 12'h0FF;
    repeat (15) step();
    check("t3_ov_held", int'(out_valid), 1);
    check("t3_not_rdy", int'(in_ready), 0);
    check("t3_sample",  int'(mac_sample), 12'h3A5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("t3_ov_rel",  int'(out_valid), 0);
    check("t3_rdy_rel", int'(in_ready), 1);

    // Soft clear during tap 1, then a full sample.
    send(12'h555);
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    check("t4_en",   int'(mac_en), 0);
    check("t4_rdy",  int'(in_ready), 1);
    check("t4_busy", int'(busy), 0);
    send(12'h0AA);
    repeat (NT) step();
    step();
    check("t4_ov", int'(out_valid), 1);
    step();

    // Soft clear wins over a same-cycle sample in IDLE.
    soft_clr = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'h123;
    step();
    soft_clr = 1'b0;
    in_valid = 1'b0;
    check("t6_rdy",  int'(in_ready), 1);
    check("t6_busy", int'(busy), 0);
    step();

    // Continuous valid: one acceptance every seven cycles.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 70; i++) begin
      in_data = DW'($urandom);
      if (in_ready) n_acc++;
      step();
    end
    in_valid = 1'b0;
    check("t5_accepts", n_acc, 10);
    wait_ready(20);

    // Randomized soak.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      soft_clr  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end
    soft_clr  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_ready(20);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
